// File: rtl/tnn_thr_cmp_bank.sv
// tnn_thr_cmp_bank: bank of CH threshold comparators with a 2-stage valid/ready pipeline.
//
// Each channel compares its W-bit feature against a programmable threshold in either
// strict (gt) or non-strict (ge) mode. DROP_LSB low bits of both operands are ignored,
// which trades accuracy for a narrower compare. Stage 1 registers the decision vector.
// Stage 2 registers the vector and its popcount (vote) and drives the outputs.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cfg_we/ch/thr/mode     per-channel threshold/mode write port (never stalls the pipe)
//   in_valid/ready/data    input sample stream, channel i at in_data[i*W +: W]
//   out_valid/ready        output stream handshake
//   out_bits, out_count    per-channel decisions and their popcount

module tnn_thr_cmp_bank #(
  parameter int unsigned W        = 3,
  parameter int unsigned CH       = 4,
  parameter int unsigned DROP_LSB = 0,
  localparam int unsigned ChW     = (CH > 1) ? $clog2(CH) : 1,
  localparam int unsigned CntW    = $clog2(CH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ChW-1:0]    cfg_ch,
  input  logic [W-1:0]      cfg_thr,
  input  logic              cfg_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH*W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH-1:0]     out_bits,
  output logic [CntW-1:0]   out_count
);

  logic [W-1:0]    thr_q [CH];
  logic [CH-1:0]   mode_q;

  logic            s1_valid_q;
  logic [CH-1:0]   s1_bits_q;
  logic            s2_valid_q;
  logic [CH-1:0]   s2_bits_q;
  logic [CntW-1:0] s2_count_q;

  logic            adv2;
  logic            accept;
  logic [CH-1:0]   dec;
  logic [CntW-1:0] pop;

  // Stage 2 can take stage 1's sample if it is empty or is being drained this cycle.
  assign adv2     = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | adv2;
  assign accept   = in_valid & in_ready;

  // Decisions use the current (pre-write) threshold/mode registers, so a sample accepted
  // in the same cycle as a config write sees the old values.
  always_comb begin
    dec = '0;
    for (int i = 0; i < CH; i++) begin
      if (mode_q[i]) begin
        dec[i] = (in_data[i*W +: W] >> DROP_LSB) >= (thr_q[i] >> DROP_LSB);
      end else begin
        dec[i] = (in_data[i*W +: W] >> DROP_LSB) > (thr_q[i] >> DROP_LSB);
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < CH; i++) begin
      pop = pop + CntW'(s1_bits_q[i]);
    end
  end

  // Threshold/mode registers. Reset leaves every channel unable to fire (max thr, gt).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        thr_q[i] <= '1;
      end
      mode_q <= '0;
    end else if (cfg_we && (int'(cfg_ch) < int'(CH))) begin
      thr_q[cfg_ch]  <= cfg_thr;
      mode_q[cfg_ch] <= cfg_mode;
    end
  end

  // Stage 1: decision vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_bits_q  <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_bits_q  <= dec;
    end else if (adv2) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2: output register; holds while out_valid & ~out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_bits_q  <= '0;
      s2_count_q <= '0;
    end else if (adv2) begin
      s2_valid_q <= 1'b1;
      s2_bits_q  <= s1_bits_q;
      s2_count_q <= pop;
    end else if (out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_bits  = s2_bits_q;
  assign out_count = s2_count_q;

endmodule

// File: tb/tb_tnn_thr_cmp_bank.sv
// Testbench for tnn_thr_cmp_bank. dut0: W=3, CH=4, DROP_LSB=0 checked against a reference
// model plus scoreboard queue. dut1: W=3, CH=3, DROP_LSB=1 for LSB truncation and an
// out-of-range channel write.

module tb_tnn_thr_cmp_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [2:0]  cfg_thr;
  logic        cfg_mode;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_bits;
  logic [2:0]  out_count;

  logic        cfg_we1;
  logic [1:0]  cfg_ch1;
  logic [2:0]  cfg_thr1;
  logic        cfg_mode1;
  logic        in_valid1;
  logic        in_ready1;
  logic [8:0]  in_data1;
  logic        out_valid1;
  logic        out_ready1;
  logic [2:0]  out_bits1;
  logic [1:0]  out_count1;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  // Reference model state and scoreboard: {count, bits}.
  logic [2:0] m_thr [4];
  logic       m_mode [4];
  logic [6:0] sb_q [$];

  always #5 clk = ~clk;

  tnn_thr_cmp_bank #(.W(3), .CH(4), .DROP_LSB(0)) dut0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_thr(cfg_thr),
    .cfg_mode(cfg_mode), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_count(out_count)
  );

  tnn_thr_cmp_bank #(.W(3), .CH(3), .DROP_LSB(1)) dut1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we1), .cfg_ch(cfg_ch1), .cfg_thr(cfg_thr1),
    .cfg_mode(cfg_mode1), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_bits(out_bits1),
    .out_count(out_count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_thr[i]  = 3'd7;
      m_mode[i] = 1'b0;
    end
  endtask

  function automatic logic [6:0] model(input logic [11:0] d);
    logic [3:0] b;
    logic [2:0] f;
    for (int i = 0; i < 4; i++) begin
      f    = d[i*3 +: 3];
      b[i] = m_mode[i] ? (f >= m_thr[i]) : (f > m_thr[i]);
    end
    return {3'($countones(b)), b};
  endfunction

  // One clock cycle: sample handshakes mid-low-phase, check against the model, advance.
  task automatic cycle(output bit acc);
    logic [6:0] e;
    #1;
    acc = in_valid && in_ready;
    if (armed && !rst) begin
      chk("in_ready", 32'(in_ready), 32'((sb_q.size() < 2) || out_ready));
      if (sb_q.size() == 0) chk("idle_out_valid", 32'(out_valid), 32'd0);
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q[0];
          chk("out_bits", 32'(out_bits), 32'(e[3:0]));
          chk("out_count", 32'(out_count), 32'(e[6:4]));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
    if (acc && !rst) sb_q.push_back(model(in_data));
    if (cfg_we && !rst) begin
      m_thr[cfg_ch]  = cfg_thr;
      m_mode[cfg_ch] = cfg_mode;
    end
    @(posedge clk);
    if (rst) begin
      sb_q.delete();
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic step();
    bit a;
    cycle(a);
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [2:0] thr, input logic mode);
    cfg_we = 1'b1; cfg_ch = ch; cfg_thr = thr; cfg_mode = mode;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic write_cfg1(input logic [1:0] ch, input logic [2:0] thr, input logic mode);
    cfg_we1 = 1'b1; cfg_ch1 = ch; cfg_thr1 = thr; cfg_mode1 = mode;
    step();
    cfg_we1 = 1'b0;
  endtask

  // Push one sample through dut1 (always ready, always empty) and check its outputs.
  task automatic send1(input string tag, input logic [8:0] d, input logic [2:0] eb,
                       input logic [1:0] ec);
    in_valid1 = 1'b1; in_data1 = d;
    step();
    in_valid1 = 1'b0;
    step();
    #1;
    chk({tag, "_valid"}, 32'(out_valid1), 32'd1);
    chk({tag, "_bits"}, 32'(out_bits1), 32'(eb));
    chk({tag, "_count"}, 32'(out_count1), 32'(ec));
  endtask

  logic [11:0] samples [6];
  int          stall_acc;
  int          idx;
  bit          a;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_thr = '0; cfg_mode = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we1 = 1'b0; cfg_ch1 = '0; cfg_thr1 = '0; cfg_mode1 = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
    model_reset();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    armed = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bits", 32'(out_bits), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_valid1", 32'(out_valid1), 32'd0);

    // All channels at max value never fire with reset thresholds; check 2-edge latency.
    in_valid = 1'b1; in_data = {3'd7, 3'd7, 3'd7, 3'd7};
    cycle(a);
    chk("s1_accept", 32'(a), 32'd1);
    in_valid = 1'b0;
    #1;
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    step();
    #1;
    chk("lat_edge2_valid", 32'(out_valid), 32'd1);
    chk("s1_bits_const", 32'(out_bits), 32'd0);
    drain(10);

    // Mixed gt/ge programming.
    write_cfg(2'd0, 3'd3, 1'b0);
    write_cfg(2'd1, 3'd3, 1'b1);
    write_cfg(2'd2, 3'd0, 1'b0);
    write_cfg(2'd3, 3'd6, 1'b1);
    in_valid = 1'b1; in_data = {3'd5, 3'd1, 3'd3, 3'd3};
    step();
    in_valid = 1'b0;
    step();
    #1;
    chk("s2_bits_const", 32'(out_bits), 32'h6);
    chk("s2_count_const", 32'(out_count), 32'd2);
    drain(10);

    // Backpressure: 5 stalled cycles with continuous valid input.
    samples[0] = {3'd7, 3'd0, 3'd4, 3'd4};
    samples[1] = {3'd6, 3'd1, 3'd3, 3'd2};
    samples[2] = {3'd0, 3'd0, 3'd0, 3'd0};
    samples[3] = {3'd5, 3'd2, 3'd2, 3'd7};
    samples[4] = {3'd6, 3'd5, 3'd3, 3'd3};
    samples[5] = {3'd7, 3'd7, 3'd7, 3'd7};
    idx = 0;
    stall_acc = 0;
    for (int c = 0; c < 40 && (idx < 6 || sb_q.size() != 0); c++) begin
      in_valid  = (idx < 6);
      in_data   = samples[(idx < 6) ? idx : 5];
      out_ready = (c >= 5);
      cycle(a);
      if (a) begin
        idx++;
        if (c < 5) stall_acc++;
      end
    end
    chk("stall_accepts", 32'(stall_acc), 32'd2);
    chk("stall_all_in", 32'(idx), 32'd6);
    drain(10);

    // Config write coincident with acceptance: that sample sees old ch0=3/gt.
    in_valid = 1'b1; in_data = {3'd0, 3'd0, 3'd0, 3'd1};
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_thr = 3'd0; cfg_mode = 1'b0;
    step();
    cfg_we = 1'b0;
    step();
    in_valid = 1'b0;
    #1;
    chk("cfg_same_cycle_bit0", 32'(out_bits[0]), 32'd0);
    step();
    #1;
    chk("cfg_next_cycle_bit0", 32'(out_bits[0]), 32'd1);
    drain(10);

    // dut1: DROP_LSB=1 and an out-of-range channel write.
    write_cfg1(2'd0, 3'd4, 1'b0);
    send1("drop_gt", {3'd0, 3'd0, 3'd5}, 3'b000, 2'd0);
    write_cfg1(2'd0, 3'd4, 1'b1);
    send1("drop_ge", {3'd0, 3'd0, 3'd5}, 3'b001, 2'd1);
    write_cfg1(2'd3, 3'd0, 1'b1);
    send1("oob_write", {3'd7, 3'd7, 3'd7}, 3'b001, 2'd1);

    // Reset with two samples in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = {3'd7, 3'd7, 3'd7, 3'd7};
    step();
    in_data = {3'd6, 3'd1, 3'd3, 3'd3};
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    in_valid = 1'b1; in_data = {3'd7, 3'd7, 3'd7, 3'd7};
    step();
    in_valid = 1'b0;
    step();
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_bits", 32'(out_bits), 32'd0);
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
